// File: rtl/controle_faixa.sv
// controle_faixa: band-hit game controller; requests range measurements and scores hits against a pseudo-random band.
// Latency: measurement request every PERIODO+2 cycles (MEDE + PERIODO x ESPERA + AVALIA); all outputs registered.
// Backpressure: none; dentro is sampled only in AVALIA, iniciar only in INICIAL/FIM.
//
// Ports:
//   clock, reset      rising-edge clock, synchronous active-high reset
//   iniciar           start/restart request
//   dentro            in-band flag from the range meter
//   medir             one-cycle measurement request
//   upperL, lowerL    band limits, 3-digit BCD centimetres
//   rodada            completed-round count
//   acertos           current consecutive-hit count
//   fim, ganhou       game over level and win/loss result
//   db_estado         debug state code
module controle_faixa #(
  parameter int PERIODO     = 5000000,
  parameter int N_ACERTOS   = 3,
  parameter int N_RODADAS   = 4,
  parameter int MAX_MEDIDAS = 50
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        iniciar,
  input  logic        dentro,
  output logic        medir,
  output logic [11:0] upperL,
  output logic [11:0] lowerL,
  output logic [2:0]  rodada,
  output logic [7:0]  acertos,
  output logic        fim,
  output logic        ganhou,
  output logic [3:0]  db_estado
);

  localparam int CW = (PERIODO > 2) ? $clog2(PERIODO) : 1;

  typedef enum logic [3:0] {
    INICIAL = 4'h0,
    SORTEIA = 4'h1,
    MEDE    = 4'h2,
    ESPERA  = 4'h3,
    AVALIA  = 4'h4,
    FIM     = 4'hF
  } estado_t;

  estado_t     estado, estado_prox;
  logic [CW-1:0] cnt, cnt_prox;
  logic [7:0]  lfsr, lfsr_prox;
  logic [7:0]  medidas, medidas_prox;
  logic [7:0]  acertos_prox;
  logic [2:0]  rodada_prox;
  logic [11:0] lower_prox, upper_prox;
  logic        medir_prox, fim_prox, ganhou_prox;

  logic [7:0]  acertos_inc;
  logic [2:0]  rodada_inc;
  logic        ganha_rodada;

  // A hit that reaches N_ACERTOS wins the round; this outranks measurement exhaustion.
  assign acertos_inc  = acertos + 8'd1;
  assign rodada_inc   = rodada + 3'd1;
  assign ganha_rodada = dentro && (acertos_inc == 8'(N_ACERTOS));

  // State register and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      estado  <= INICIAL;
      cnt     <= '0;
      lfsr    <= 8'hA5;
      medidas <= 8'd0;
      acertos <= 8'd0;
      rodada  <= 3'd0;
      lowerL  <= 12'h000;
      upperL  <= 12'h000;
      medir   <= 1'b0;
      fim     <= 1'b0;
      ganhou  <= 1'b0;
    end else begin
      estado  <= estado_prox;
      cnt     <= cnt_prox;
      lfsr    <= lfsr_prox;
      medidas <= medidas_prox;
      acertos <= acertos_prox;
      rodada  <= rodada_prox;
      lowerL  <= lower_prox;
      upperL  <= upper_prox;
      medir   <= medir_prox;
      fim     <= fim_prox;
      ganhou  <= ganhou_prox;
    end
  end

  assign db_estado = estado;

  // Next-state logic.
  always_comb begin
    estado_prox = estado;
    case (estado)
      INICIAL: if (iniciar) estado_prox = SORTEIA;
      SORTEIA: estado_prox = MEDE;
      MEDE:    estado_prox = ESPERA;
      ESPERA:  if (cnt == CW'(PERIODO - 1)) estado_prox = AVALIA;
      AVALIA: begin
        if (ganha_rodada) begin
          estado_prox = (rodada_inc == 3'(N_RODADAS)) ? FIM : SORTEIA;
        end else if (medidas == 8'(MAX_MEDIDAS)) begin
          estado_prox = FIM;
        end else begin
          estado_prox = MEDE;
        end
      end
      FIM:     if (iniciar) estado_prox = SORTEIA;
      default: estado_prox = INICIAL;
    endcase
  end

  // Next values of the registered outputs and datapath.
  always_comb begin
    medir_prox   = (estado_prox == MEDE);
    fim_prox     = (estado_prox == FIM);
    ganhou_prox  = ganhou;
    rodada_prox  = rodada;
    acertos_prox = acertos;
    medidas_prox = medidas;
    lfsr_prox    = lfsr;
    lower_prox   = lowerL;
    upper_prox   = upperL;
    // Counter only runs while staying in ESPERA, so every entry starts at zero.
    cnt_prox     = (estado == ESPERA && estado_prox == ESPERA) ? cnt + CW'(1) : '0;
    case (estado)
      SORTEIA: begin
        case (lfsr[1:0])
          2'b00:   begin lower_prox = 12'h010; upper_prox = 12'h020; end
          2'b01:   begin lower_prox = 12'h020; upper_prox = 12'h030; end
          2'b10:   begin lower_prox = 12'h030; upper_prox = 12'h040; end
          default: begin lower_prox = 12'h040; upper_prox = 12'h050; end
        endcase
        acertos_prox = 8'd0;
        medidas_prox = 8'd0;
        lfsr_prox    = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      end
      MEDE: medidas_prox = medidas + 8'd1;
      AVALIA: begin
        acertos_prox = dentro ? acertos_inc : 8'd0;
        if (ganha_rodada) rodada_prox = rodada_inc;
        if (estado_prox == FIM) ganhou_prox = ganha_rodada;
      end
      FIM: begin
        // Restart keeps the LFSR running so the next game draws new bands.
        if (iniciar) begin
          rodada_prox = 3'd0;
          ganhou_prox = 1'b0;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_controle_faixa.sv
// tb_controle_faixa: directed table plus randomized games against a measurement-level game model.
// Latency: follows the PERIODO+2 request cadence of the design under test.
// Backpressure: none; inputs driven 1 time unit after each rising edge.
module tb_controle_faixa;

  localparam int PERIODO     = 4;
  localparam int N_ACERTOS   = 2;
  localparam int N_RODADAS   = 2;
  localparam int MAX_MEDIDAS = 3;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        iniciar = 1'b0;
  logic        dentro = 1'b0;
  logic        medir;
  logic [11:0] upperL, lowerL;
  logic [2:0]  rodada;
  logic [7:0]  acertos;
  logic        fim, ganhou;
  logic [3:0]  db_estado;

  int n_chk  = 0;
  int n_pass = 0;

  // Game model state, advanced once per measurement.
  logic [7:0]  m_lfsr;
  logic [11:0] m_low, m_up;
  int          m_rod, m_acc, m_med;

  controle_faixa #(
    .PERIODO(PERIODO), .N_ACERTOS(N_ACERTOS),
    .N_RODADAS(N_RODADAS), .MAX_MEDIDAS(MAX_MEDIDAS)
  ) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .dentro(dentro),
    .medir(medir), .upperL(upperL), .lowerL(lowerL), .rodada(rodada),
    .acertos(acertos), .fim(fim), .ganhou(ganhou), .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        start;
    logic        d;
    logic [11:0] low;
    logic [11:0] up;
    int          acc;
    int          rod;
    int          st;
    int          fim_e;
    int          gan;
  } vec_t;

  vec_t tab[13];

  task automatic chk(input string nome, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nome, act, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  function automatic void sortear();
    int idx;
    idx    = int'(m_lfsr[1:0]);
    m_low  = 12'((idx + 1) * 16);
    m_up   = 12'((idx + 2) * 16);
    m_lfsr = lfsr_next(m_lfsr);
    m_acc  = 0;
    m_med  = 0;
  endfunction

  // From INICIAL/FIM: pulse iniciar, expect SORTEIA then the first medir.
  task automatic start_game();
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    chk("start_estado", int'(db_estado), 1);
    chk("start_fim", int'(fim), 0);
    chk("start_rodada", int'(rodada), 0);
    chk("start_ganhou", int'(ganhou), 0);
    tick();
    chk("start_medir", int'(medir), 1);
  endtask

  // Called just after the edge that raised medir. dentro is noise except in
  // the AVALIA cycle; returns just after the edge that completes AVALIA.
  task automatic meas(input logic d);
    int altos;
    altos = 0;
    for (int i = 1; i <= PERIODO + 2; i++) begin
      dentro = (i == PERIODO + 2) ? d : 1'($urandom);
      tick();
      if (i <= PERIODO + 1 && medir) altos++;
    end
    chk("medir_largura", altos, 0);
  endtask

  task automatic check_after(input string tag, input int acc, input int rod,
                             input int st, input int fe, input int gan);
    chk({tag, "_acertos"}, int'(acertos), acc);
    chk({tag, "_rodada"}, int'(rodada), rod);
    chk({tag, "_estado"}, int'(db_estado), st);
    chk({tag, "_fim"}, int'(fim), fe);
    chk({tag, "_ganhou"}, int'(ganhou), gan);
    chk({tag, "_medir"}, int'(medir), (st == 2) ? 1 : 0);
    if (st == 1) begin
      tick();
      chk({tag, "_medir_nova"}, int'(medir), 1);
      chk({tag, "_acertos_nova"}, int'(acertos), 0);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_estado"}, int'(db_estado), 0);
    chk({tag, "_medir"}, int'(medir), 0);
    chk({tag, "_fim"}, int'(fim), 0);
    chk({tag, "_ganhou"}, int'(ganhou), 0);
    chk({tag, "_rodada"}, int'(rodada), 0);
    chk({tag, "_acertos"}, int'(acertos), 0);
    chk({tag, "_lower"}, int'(lowerL), 0);
    chk({tag, "_upper"}, int'(upperL), 0);
  endtask

  initial begin
    int   pulsos;
    int   st, gan;
    logic d;
    logic done;

    //            start d  lower    upper    acc rod st  fim gan
    tab[0]  = '{1'b1, 1'b1, 12'h020, 12'h030, 1, 0, 2,  0, 0};
    tab[1]  = '{1'b0, 1'b1, 12'h020, 12'h030, 2, 1, 1,  0, 0};
    tab[2]  = '{1'b0, 1'b1, 12'h030, 12'h040, 1, 1, 2,  0, 0};
    tab[3]  = '{1'b0, 1'b1, 12'h030, 12'h040, 2, 2, 15, 1, 1};
    tab[4]  = '{1'b1, 1'b1, 12'h020, 12'h030, 1, 0, 2,  0, 0};
    tab[5]  = '{1'b0, 1'b0, 12'h020, 12'h030, 0, 0, 2,  0, 0};
    tab[6]  = '{1'b0, 1'b1, 12'h020, 12'h030, 1, 0, 15, 1, 0};
    tab[7]  = '{1'b1, 1'b0, 12'h030, 12'h040, 0, 0, 2,  0, 0};
    tab[8]  = '{1'b0, 1'b1, 12'h030, 12'h040, 1, 0, 2,  0, 0};
    tab[9]  = '{1'b0, 1'b1, 12'h030, 12'h040, 2, 1, 1,  0, 0};
    tab[10] = '{1'b0, 1'b0, 12'h010, 12'h020, 0, 1, 2,  0, 0};
    tab[11] = '{1'b0, 1'b0, 12'h010, 12'h020, 0, 1, 2,  0, 0};
    tab[12] = '{1'b0, 1'b0, 12'h010, 12'h020, 0, 1, 15, 1, 0};

    // Reset dominates iniciar and dentro.
    reset = 1'b1; iniciar = 1'b1; dentro = 1'b1;
    tick(); tick(); tick();
    chk_reset_vals("rst_inicial");
    reset = 1'b0; iniciar = 1'b0; dentro = 1'b0;
    tick(); tick();
    chk("inicial_espera", int'(db_estado), 0);

    // Directed games: win, loss with broken streak, round win on last measurement.
    for (int k = 0; k < 13; k++) begin
      if (tab[k].start) start_game();
      chk($sformatf("tab%0d_lower", k), int'(lowerL), int'(tab[k].low));
      chk($sformatf("tab%0d_upper", k), int'(upperL), int'(tab[k].up));
      meas(tab[k].d);
      check_after($sformatf("tab%0d", k), tab[k].acc, tab[k].rod,
                  tab[k].st, tab[k].fim_e, tab[k].gan);
    end

    // FIM holds everything while dentro toggles.
    for (int i = 0; i < 6; i++) begin
      dentro = ~dentro;
      tick();
    end
    chk("fim_hold_estado", int'(db_estado), 15);
    chk("fim_hold_fim", int'(fim), 1);
    chk("fim_hold_ganhou", int'(ganhou), 0);
    chk("fim_hold_rodada", int'(rodada), 1);
    chk("fim_hold_acertos", int'(acertos), 0);
    chk("fim_hold_lower", int'(lowerL), 12'h010);
    chk("fim_hold_upper", int'(upperL), 12'h020);
    chk("fim_hold_medir", int'(medir), 0);

    // Reset in the middle of ESPERA, with iniciar and dentro also high.
    start_game();
    chk("d_lower", int'(lowerL), 12'h020);
    chk("d_upper", int'(upperL), 12'h030);
    tick(); tick();
    chk("d_espera", int'(db_estado), 3);
    reset = 1'b1; iniciar = 1'b1; dentro = 1'b1;
    tick();
    chk_reset_vals("rst_espera");
    reset = 1'b0; iniciar = 1'b0; dentro = 1'b0;
    pulsos = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (medir) pulsos++;
    end
    chk("rst_sem_medir", pulsos, 0);
    chk("rst_ocioso", int'(db_estado), 0);

    // Randomized games against the model; the LFSR restarts from its reset seed.
    m_lfsr = 8'hA5;
    for (int g = 0; g < 10; g++) begin
      m_rod = 0;
      sortear();
      start_game();
      done = 1'b0;
      while (!done) begin
        chk("rnd_lower", int'(lowerL), int'(m_low));
        chk("rnd_upper", int'(upperL), int'(m_up));
        chk("rnd_rodada_med", int'(rodada), m_rod);
        d = ($urandom_range(0, 99) < 70);
        m_med++;
        m_acc = d ? m_acc + 1 : 0;
        st = 2;
        gan = 0;
        if (d && m_acc == N_ACERTOS) begin
          m_rod++;
          if (m_rod == N_RODADAS) begin st = 15; gan = 1; end
          else st = 1;
        end else if (m_med == MAX_MEDIDAS) begin
          st = 15;
        end
        meas(d);
        check_after("rnd", m_acc, m_rod, st, (st == 15) ? 1 : 0, gan);
        if (st == 1) sortear();
        if (st == 15) done = 1'b1;
      end
      for (int i = 0; i < int'($urandom_range(1, 5)); i++) begin
        dentro = 1'($urandom);
        tick();
      end
      chk("rnd_fim_hold", int'(fim), 1);
      chk("rnd_ganhou_hold", int'(ganhou), gan);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
